// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar definitions.
// Response encodings and slave-index width used by the master-port logic.
package axi_xbar_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned SLV_IDX_W = 2;

    typedef logic [SLV_IDX_W-1:0] slv_idx_t;

endpackage

// File: rtl/ot_age_matrix.sv
// Age matrix for the outstanding-write table.
// older[i][j] set means entry j was allocated before entry i.
module ot_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] set_vec,
    input  logic [DEPTH-1:0] row_val,
    input  logic [DEPTH-1:0] clr_vec,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] sel
);

    logic [DEPTH-1:0] older [DEPTH];

    // Column clear wins over the new row so a same-cycle release never
    // leaves a stale "older" bit behind in the freshly written entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (set_vec[i]) begin
                    older[i] <= row_val & ~clr_vec;
                end else begin
                    older[i] <= older[i] & ~clr_vec;
                end
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = req[i] && ((older[i] & req) == '0);
        end
    end

endmodule

// File: rtl/axi_ot_tracker.sv
// Outstanding-write tracker for the AXI crossbar master port.
// Keeps same-ID writes on one slave and releases the oldest match per B.
module axi_ot_tracker
    import axi_xbar_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int ID_W  = 4,
    parameter  int SLV_W = SLV_IDX_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic [SLV_W-1:0] alloc_slave,
    input  logic [ID_W-1:0]  alloc_id,
    input  logic             alloc_fk,
    output logic             alloc_ready,
    input  logic             rsp_fire,
    input  logic [ID_W-1:0]  rsp_id,
    output logic             rsp_hit,
    output logic [SLV_W-1:0] rsp_slave,
    output logic             rsp_fk,
    output logic             rsp_orphan,
    output logic [DEPTH-1:0] entry_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] fk_q;
    logic [ID_W-1:0]  id_q  [DEPTH];
    logic [SLV_W-1:0] slv_q [DEPTH];

    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] alloc_vec;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] sel;
    logic [DEPTH-1:0] rel_vec;
    logic             conflict;
    logic             alloc_go;

    assign free_vec  = ~vld;
    assign alloc_vec = free_vec & (~free_vec + DEPTH'(1));

    always_comb begin
        conflict = 1'b0;
        cand     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && id_q[i] == alloc_id && slv_q[i] != alloc_slave) begin
                conflict = 1'b1;
            end
            cand[i] = vld[i] && (id_q[i] == rsp_id);
        end
    end

    assign full        = &vld;
    assign empty       = ~|vld;
    assign entry_valid = vld;
    assign alloc_ready = !full && !conflict;
    assign alloc_go    = alloc_valid && alloc_ready;
    assign set_vec     = alloc_go ? alloc_vec : '0;
    assign rel_vec     = rsp_fire ? sel : '0;

    ot_age_matrix #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_vec (set_vec),
        .row_val (vld),
        .clr_vec (rel_vec),
        .req     (cand),
        .sel     (sel)
    );

    always_comb begin
        rsp_slave = '0;
        rsp_fk    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rel_vec[i]) begin
                rsp_slave = rsp_slave | slv_q[i];
                rsp_fk    = rsp_fk | fk_q[i];
            end
        end
    end

    assign rsp_hit    = |rel_vec;
    assign rsp_orphan = rsp_fire && !rsp_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            fk_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]  <= '0;
                slv_q[i] <= '0;
            end
        end else begin
            vld <= (vld & ~rel_vec) | set_vec;
            for (int i = 0; i < DEPTH; i++) begin
                if (set_vec[i]) begin
                    id_q[i]  <= alloc_id;
                    slv_q[i] <= alloc_slave;
                    fk_q[i]  <= alloc_fk;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else begin
            unique case ({alloc_go, rsp_hit})
                2'b10:   out_count <= out_count + CNT_W'(1);
                2'b01:   out_count <= out_count - CNT_W'(1);
                default: out_count <= out_count;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (out_count == CNT_W'($countones(vld)))
            else $error("out_count %0d disagrees with entry_valid %b",
                        out_count, vld);
        end
    end

endmodule

// File: tb/tb_axi_ot_tracker.sv
// Directed bench for axi_ot_tracker (DEPTH=4, ID_W=4, SLV_W=2).
// Inputs change on the falling edge; state is checked after the rising edge.
module tb_axi_ot_tracker;

    logic       clk;
    logic       rst_n;
    logic       alloc_valid;
    logic [1:0] alloc_slave;
    logic [3:0] alloc_id;
    logic       alloc_fk;
    logic       alloc_ready;
    logic       rsp_fire;
    logic [3:0] rsp_id;
    logic       rsp_hit;
    logic [1:0] rsp_slave;
    logic       rsp_fk;
    logic       rsp_orphan;
    logic [3:0] entry_valid;
    logic [2:0] out_count;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    axi_ot_tracker #(
        .DEPTH (4),
        .ID_W  (4),
        .SLV_W (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_slave (alloc_slave),
        .alloc_id    (alloc_id),
        .alloc_fk    (alloc_fk),
        .alloc_ready (alloc_ready),
        .rsp_fire    (rsp_fire),
        .rsp_id      (rsp_id),
        .rsp_hit     (rsp_hit),
        .rsp_slave   (rsp_slave),
        .rsp_fk      (rsp_fk),
        .rsp_orphan  (rsp_orphan),
        .entry_valid (entry_valid),
        .out_count   (out_count),
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_alloc(input logic [3:0] id, input logic [1:0] slv,
                            input logic fk);
        alloc_valid = 1'b1;
        alloc_id    = id;
        alloc_slave = slv;
        alloc_fk    = fk;
        @(posedge clk);
        #1 alloc_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_rsp(input logic [3:0] id);
        rsp_fire = 1'b1;
        rsp_id   = id;
        @(posedge clk);
        #1 rsp_fire = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        alloc_valid = 1'b0;
        alloc_slave = '0;
        alloc_id    = '0;
        alloc_fk    = 1'b0;
        rsp_fire    = 1'b0;
        rsp_id      = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(entry_valid), 32'h0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_hit", 32'(rsp_hit), 32'd0);
        chk("rst_orphan", 32'(rsp_orphan), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_alloc(4'd3, 2'd1, 1'b0);
        chk("a1_valid", 32'(entry_valid), 32'h1);
        chk("a1_count", 32'(out_count), 32'd1);
        chk("a1_empty", 32'(empty), 32'd0);
        rsp_fire = 1'b1;
        rsp_id   = 4'd3;
        #1;
        chk("r1_hit", 32'(rsp_hit), 32'd1);
        chk("r1_slave", 32'(rsp_slave), 32'd1);
        chk("r1_orphan", 32'(rsp_orphan), 32'd0);
        @(posedge clk);
        #1 rsp_fire = 1'b0;
        @(negedge clk);
        chk("r1_empty", 32'(empty), 32'd1);
        chk("r1_count", 32'(out_count), 32'd0);

        do_alloc(4'd5, 2'd0, 1'b0);
        alloc_id    = 4'd5;
        alloc_slave = 2'd2;
        #1 chk("conf_ready", 32'(alloc_ready), 32'd0);
        alloc_slave = 2'd0;
        #1 chk("same_ready", 32'(alloc_ready), 32'd1);
        @(negedge clk);
        do_rsp(4'd5);
        chk("c_empty", 32'(empty), 32'd1);

        do_alloc(4'd1, 2'd0, 1'b0);
        do_alloc(4'd2, 2'd0, 1'b0);
        do_alloc(4'd3, 2'd0, 1'b0);
        do_alloc(4'd4, 2'd0, 1'b0);
        chk("f_full", 32'(full), 32'd1);
        chk("f_count", 32'(out_count), 32'd4);
        alloc_valid = 1'b1;
        alloc_id    = 4'd6;
        alloc_slave = 2'd1;
        rsp_fire    = 1'b1;
        rsp_id      = 4'd2;
        #1;
        chk("f_ready", 32'(alloc_ready), 32'd0);
        chk("f_hit", 32'(rsp_hit), 32'd1);
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        rsp_fire    = 1'b0;
        @(negedge clk);
        chk("f_full2", 32'(full), 32'd0);
        chk("f_valid", 32'(entry_valid), 32'hd);
        chk("f_count2", 32'(out_count), 32'd3);
        do_rsp(4'd1);
        do_rsp(4'd3);
        do_rsp(4'd4);
        chk("f_empty", 32'(empty), 32'd1);

        do_alloc(4'd7, 2'd0, 1'b1);
        do_alloc(4'd7, 2'd0, 1'b0);
        rsp_fire = 1'b1;
        rsp_id   = 4'd7;
        #1 chk("o_fk_first", 32'(rsp_fk), 32'd1);
        @(posedge clk);
        #1 rsp_fire = 1'b0;
        @(negedge clk);
        chk("o_valid1", 32'(entry_valid), 32'h2);
        do_alloc(4'd7, 2'd0, 1'b1);
        chk("o_valid2", 32'(entry_valid), 32'h3);
        rsp_fire = 1'b1;
        rsp_id   = 4'd7;
        #1;
        chk("o_hit", 32'(rsp_hit), 32'd1);
        chk("o_fk_old", 32'(rsp_fk), 32'd0);
        @(posedge clk);
        #1 rsp_fire = 1'b0;
        @(negedge clk);
        chk("o_valid3", 32'(entry_valid), 32'h1);
        do_rsp(4'd7);
        chk("o_empty", 32'(empty), 32'd1);

        do_alloc(4'd8, 2'd1, 1'b0);
        do_alloc(4'd10, 2'd2, 1'b0);
        alloc_valid = 1'b1;
        alloc_id    = 4'd9;
        alloc_slave = 2'd3;
        rsp_fire    = 1'b1;
        rsp_id      = 4'd8;
        #1 chk("s_ready", 32'(alloc_ready), 32'd1);
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        rsp_fire    = 1'b0;
        @(negedge clk);
        chk("s_count", 32'(out_count), 32'd2);
        chk("s_valid", 32'(entry_valid), 32'h6);
        rsp_fire = 1'b1;
        rsp_id   = 4'd9;
        #1 chk("s_slave9", 32'(rsp_slave), 32'd3);
        @(posedge clk);
        #1 rsp_fire = 1'b0;
        @(negedge clk);
        rsp_fire = 1'b1;
        rsp_id   = 4'd10;
        #1 chk("s_slave10", 32'(rsp_slave), 32'd2);
        @(posedge clk);
        #1 rsp_fire = 1'b0;
        @(negedge clk);
        chk("s_empty", 32'(empty), 32'd1);

        do_alloc(4'd1, 2'd0, 1'b0);
        do_alloc(4'd2, 2'd1, 1'b0);
        do_alloc(4'd3, 2'd2, 1'b0);
        rsp_fire = 1'b1;
        rsp_id   = 4'he;
        #1;
        chk("orph_flag", 32'(rsp_orphan), 32'd1);
        chk("orph_hit", 32'(rsp_hit), 32'd0);
        chk("orph_slave", 32'(rsp_slave), 32'd0);
        @(posedge clk);
        #1 rsp_fire = 1'b0;
        @(negedge clk);
        chk("orph_valid", 32'(entry_valid), 32'h7);
        chk("orph_count", 32'(out_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(entry_valid), 32'h0);
        chk("arst_count", 32'(out_count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
